// File: rtl/pulse_gen.sv
// pulse_gen: programmable high/low level-waveform transmitter started by a one-cycle strobe.
// Optional rise_flag/fall_flag outputs are enabled by defining PULSE_GEN_EDGE_FLAGS_EN.
module pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             abort,
  output logic             dout,
  output logic             busy,
  output logic             done
`ifdef PULSE_GEN_EDGE_FLAGS_EN
  ,
  output logic             rise_flag,
  output logic             fall_flag
`endif
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, hi_m1, lo_m1;
  logic [NUM_W-1:0] pcnt;
  logic [CNT_W-1:0] hi_load, lo_load;
  // A zero length counts as one cycle, so both map to a terminal count of 0.
  assign hi_load = (high_len == '0) ? '0 : high_len - CNT_W'(1);
  assign lo_load = (low_len == '0) ? '0 : low_len - CNT_W'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      hi_m1 <= '0;
      lo_m1 <= '0;
      pcnt  <= '0;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
      rise_flag <= 1'b0;
      fall_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
      rise_flag <= 1'b0;
      fall_flag <= 1'b0;
`endif
      if (abort && busy) begin
        state <= IDLE;
        dout  <= 1'b0;
        busy  <= 1'b0;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
        fall_flag <= dout;
`endif
      end else begin
        case (state)
          IDLE, DONE: begin
            state <= IDLE;
            if (start && !abort) begin
              hi_m1 <= hi_load;
              lo_m1 <= lo_load;
              pcnt  <= num_pulses;
              cnt   <= hi_load;
              if (num_pulses == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= HIGH;
                dout  <= 1'b1;
                busy  <= 1'b1;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
                rise_flag <= 1'b1;
`endif
              end
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              state <= LOW;
              dout  <= 1'b0;
              cnt   <= lo_m1;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
              fall_flag <= 1'b1;
`endif
            end else cnt <= cnt - CNT_W'(1);
          end
          LOW: begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            else if (pcnt == NUM_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pcnt  <= '0;
            end else begin
              state <= HIGH;
              dout  <= 1'b1;
              pcnt  <= pcnt - NUM_W'(1);
              cnt   <= hi_m1;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
              rise_flag <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed self-checking bench for pulse_gen; k counts edges after start is driven.
module tb_pulse_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] high_len = '0, low_len = '0;
  logic [7:0] num_pulses = '0;
  logic dout, busy, done;
  int vectors = 0, miscompares = 0;
  int pos_cnt = 0, neg_cnt = 0;
  logic prev_dout = 1'b0;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
  logic rise_flag, fall_flag;
`endif

  pulse_gen dut (
    .clk(clk), .reset(reset), .start(start), .high_len(high_len), .low_len(low_len),
    .num_pulses(num_pulses), .abort(abort), .dout(dout), .busy(busy), .done(done)
`ifdef PULSE_GEN_EDGE_FLAGS_EN
    , .rise_flag(rise_flag), .fall_flag(fall_flag)
`endif
  );

  always #5 clk = ~clk;

  // Reference edge detector: flags a dout change one cycle after it happens.
  always @(posedge clk) begin
    if (dout && !prev_dout) pos_cnt++;
    if (!dout && prev_dout) neg_cnt++;
    prev_dout = dout;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [15:0] h, input logic [15:0] l, input logic [7:0] n);
    high_len = h;
    low_len = l;
    num_pulses = n;
    start = 1'b1;
  endtask

  initial begin
    int p0, n0;
    logic exp_dout;
    #22 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_idle", {dout, busy, done}, 3'b000);
    end

    // Basic: h=3 l=2 n=2
    p0 = pos_cnt;
    n0 = neg_cnt;
    launch(16'd3, 16'd2, 8'd2);
    for (int k = 1; k <= 12; k++) begin
      step();
      start = 1'b0;
      exp_dout = (k >= 1 && k <= 3) || (k >= 6 && k <= 8);
      check($sformatf("basic_k%0d", k), {dout, busy, done},
            {exp_dout, (k <= 10) ? 1'b1 : 1'b0, (k == 11) ? 1'b1 : 1'b0});
`ifdef PULSE_GEN_EDGE_FLAGS_EN
      check($sformatf("flags_k%0d", k), {rise_flag, fall_flag},
            {(k == 1 || k == 6) ? 1'b1 : 1'b0, (k == 4 || k == 9) ? 1'b1 : 1'b0});
`endif
    end
    check("detector_pos", pos_cnt - p0, 2);
    check("detector_neg", neg_cnt - n0, 2);

    // num_pulses = 0
    launch(16'd4, 16'd4, 8'd0);
    step();
    start = 1'b0;
    check("np0_k1", {dout, busy, done}, 3'b001);
    step();
    check("np0_k2", {dout, busy, done}, 3'b000);

    // zero lengths, 3 pulses: dout toggles every cycle
    launch(16'd0, 16'd0, 8'd3);
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      check($sformatf("zero_k%0d", k), {dout, busy, done},
            {(k <= 5 && k % 2 == 1) ? 1'b1 : 1'b0, (k <= 6) ? 1'b1 : 1'b0, (k == 7) ? 1'b1 : 1'b0});
    end

    // start while busy is ignored
    launch(16'd3, 16'd2, 8'd1);
    for (int k = 1; k <= 7; k++) begin
      step();
      start = 1'b0;
      if (k == 2) launch(16'd10, 16'd10, 8'd5);
      check($sformatf("busy_ign_k%0d", k), {dout, done},
            {(k <= 3) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0});
    end

    // start accepted in the DONE cycle
    launch(16'd1, 16'd1, 8'd1);
    step();
    start = 1'b0;
    check("b2b_a1", {dout, busy, done}, 3'b110);
    step();
    check("b2b_a2", {dout, busy, done}, 3'b010);
    step();
    check("b2b_a3", {dout, busy, done}, 3'b001);
    launch(16'd2, 16'd1, 8'd1);
    step();
    start = 1'b0;
    check("b2b_b1", {dout, busy, done}, 3'b110);
    step();
    check("b2b_b2", {dout, busy, done}, 3'b110);
    step();
    check("b2b_b3", {dout, busy, done}, 3'b010);
    step();
    check("b2b_b4", {dout, busy, done}, 3'b001);
    step();

    // abort during the second HIGH phase
    launch(16'd3, 16'd2, 8'd2);
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
    end
    check("abort_pre", {dout, busy, done}, 3'b110);
    abort = 1'b1;
    step();
    abort = 1'b0;
`ifdef PULSE_GEN_EDGE_FLAGS_EN
    check("abort_fall_flag", fall_flag, 1'b1);
`endif
    for (int k = 7; k <= 12; k++) begin
      check($sformatf("abort_k%0d", k), {dout, busy, done}, 3'b000);
      step();
    end

    // start and abort together in IDLE
    launch(16'd2, 16'd2, 8'd2);
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("start_abort_k%0d", k), {dout, busy, done}, 3'b000);
      step();
    end

    // max-value lengths run without wrap-around
    launch(16'hFFFF, 16'd1, 8'hFF);
    step();
    start = 1'b0;
    repeat (1000) step();
    check("max_len_high", {dout, busy, done}, 3'b110);

    // asynchronous reset mid-sequence
    #2 reset = 1'b1;
    #1 check("async_reset", {dout, busy, done}, 3'b000);
    #3 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("post_reset_k%0d", k), {dout, busy, done}, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
Programmable level-waveform transmitter: on a start strobe it drives dout through num_pulses repetitions of a high_len-cycle high phase followed by a low_len-cycle low phase.
It is the stimulus-side counterpart of the edge detector, producing the rising and falling edges that the detector consumes.
It is used both in-system and as a bench driver for edge-detect logic.

Parameters:
CNT_W, 16, width of the high_len/low_len phase counters (max phase 2^CNT_W-1 cycles)
NUM_W, 8, width of num_pulses and the pulse counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; latches high_len/low_len/num_pulses
high_len  input  CNT_W  high-phase length in cycles
low_len  input  CNT_W  low-phase length in cycles
num_pulses  input  NUM_W  number of high/low periods
abort  input  1  synchronous cancel of a running sequence
dout  output  1  generated waveform, registered
busy  output  1  sequence in progress
done  output  1  one-cycle strobe at normal sequence completion

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset: dout=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-sequence truncates immediately, with no done pulse.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, HIGH, LOW, DONE.
- IDLE: start=1 at edge N latches high_len, low_len and num_pulses, then:
  - Normal case: goes to HIGH, with dout=1 and busy=1 from edge N+1.
  - num_pulses=0: goes straight to DONE (done=1 from edge N+1 for one cycle); dout stays 0.
- Zero lengths: high_len=0 or low_len=0 is treated as 1 (minimum phase is 1 cycle).
- HIGH: dout=1 for exactly high_len cycles, then enters LOW with dout=0.
- LOW: dout=0 for exactly low_len cycles. At phase end:
  - Pulses remaining: back to HIGH.
  - Last pulse: goes to DONE.
- DONE: lasts one cycle; done=1, busy=0, dout=0. Next state is IDLE. A start in the DONE cycle is accepted exactly as in IDLE (back-to-back sequences).
- Timing: start at edge N gives done high between edges N+num_pulses*(high_len+low_len)+1 and +2.
- start while busy=1 is ignored; latched parameters do not change mid-sequence.
- abort=1 while busy: next edge forces dout=0, busy=0, state=IDLE, no done pulse. abort in IDLE/DONE has no effect beyond suppressing start.
- start and abort in the same cycle: abort wins; start is dropped.
- Counters: phase counter loads len-1 and counts down to 0; the pulse counter decrements at each LOW end. No wrap-around; max values (all ones) must work.

Optional Feature:
Macro PULSE_GEN_EDGE_FLAGS_EN.
- Defined: adds two outputs, rise_flag and fall_flag (1 bit each, reset 0).
  - rise_flag is high for exactly the first cycle of each HIGH phase (dout 0->1).
  - fall_flag is high for exactly the first cycle after dout 1->0, including the transition caused by abort.
  - Both flags are registered and cycle-aligned with the dout change, matching what a downstream edge detector flags one cycle later.
- Undefined: ports and logic are absent; dout/busy/done behaviour is identical.

Test Plan:
- Reset defaults: reset asserted asynchronously mid-cycle -> dout=0, busy=0, done=0 immediately; outputs stay at reset values 3 cycles after release with start=0.
- Basic sequence: start at edge 0 with high_len=3, low_len=2, num_pulses=2 -> dout rises at edges 1 and 6 and falls at edges 4 and 9; done high between edges 11 and 12; busy high edges 1-11.
- Boundaries:
  - num_pulses=0 -> done one cycle after start, dout never rises.
  - high_len=0, low_len=0, num_pulses=3 -> dout toggles every cycle, 3 highs.
- Busy handling:
  - start pulsed while busy -> ignored, no parameter change.
  - start in DONE cycle -> second sequence starts with dout=1 on the next edge.
- Abort:
  - abort during the 2nd HIGH phase -> dout=0 and busy=0 next edge, no done.
  - start+abort in the same IDLE cycle -> nothing starts.
- Edge flags (PULSE_GEN_EDGE_FLAGS_EN defined): high_len=3, low_len=2, num_pulses=2 -> rise_flag at edges 1 and 6, fall_flag at edges 4 and 9, one cycle each; an instantiated edge detector reports posEdge=2 and negEdge=2.
